// File: rtl/secded_decoder.sv
// secded_decoder: SECDED Hamming decoder in a two-stage elastic valid/ready
// pipeline. It corrects single-bit errors and flags double-bit errors. It also
// keeps saturating counters of the corrected and uncorrectable words it delivers.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   dat_i/vld_i/rdy_o      codeword input handshake
//   dat_o/err_sec_o/
//   err_ded_o/vld_o/rdy_i  corrected data + error flags, output handshake
//   cnt_clr_i              synchronous clear of both counters
//   sec_cnt_o/ded_cnt_o    saturating counts of delivered SEC / DED words
//
// Codeword layout: index i (0..CODE_W-2) is Hamming position i+1. Parity bits
// sit at power-of-two positions and data bits fill the rest, LSB first. The top
// index holds even parity over the whole word.
module secded_decoder #(
    parameter  int DATA_W = 16,
    parameter  int CNT_W  = 16,
    // Smallest p with 2^p >= DATA_W+p+1, valid for DATA_W in 4..57.
    localparam int PAR_W  = (DATA_W <= 4)  ? 3 :
                            (DATA_W <= 11) ? 4 :
                            (DATA_W <= 26) ? 5 : 6,
    localparam int CODE_W = DATA_W + PAR_W + 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [CODE_W-1:0] dat_i,
    input  logic              vld_i,
    output logic              rdy_o,
    output logic [DATA_W-1:0] dat_o,
    output logic              err_sec_o,
    output logic              err_ded_o,
    output logic              vld_o,
    input  logic              rdy_i,
    input  logic              cnt_clr_i,
    output logic [CNT_W-1:0]  sec_cnt_o,
    output logic [CNT_W-1:0]  ded_cnt_o
);

    // Hamming position of the k-th data bit (k-th non-power-of-two position).
    function automatic int f_dpos(input int k);
        int pos;
        int cnt;
        pos = 0;
        cnt = -1;
        while (cnt < k) begin
            pos++;
            if ((pos & (pos - 1)) != 0) cnt++;
        end
        return pos;
    endfunction

    logic              r_v1, r_v2;
    logic [CODE_W-2:0] r_cw1;
    logic [PAR_W-1:0]  r_syn1;
    logic              r_pa1;
    logic [DATA_W-1:0] r_dat;
    logic              r_sec, r_ded;
    logic [CNT_W-1:0]  r_sec_cnt, r_ded_cnt;

    logic              w_go1, w_rdy, w_xfer;
    logic [PAR_W-1:0]  w_syn;
    logic              w_pa;
    logic [CODE_W-2:0] w_fix;
    logic [DATA_W-1:0] w_data;
    logic              w_sec, w_ded;

    // Stage 2 advances when it is empty or being drained. Stage 1 accepts
    // when it is empty or advancing.
    assign w_go1  = ~r_v2 | rdy_i;
    assign w_rdy  = ~r_v1 | w_go1;
    assign w_xfer = r_v2 & rdy_i;

    // Syndrome is the XOR of the positions of all set bits, overall parity excluded.
    always_comb begin
        w_syn = '0;
        for (int i = 0; i < CODE_W - 1; i++)
            if (dat_i[i]) w_syn = w_syn ^ PAR_W'(i + 1);
    end
    assign w_pa = ^dat_i;

    always_comb begin
        w_fix = r_cw1;
        w_sec = 1'b0;
        w_ded = 1'b0;
        if (r_pa1) begin
            if (r_syn1 == '0) begin
                // Only the overall parity bit flipped; data is intact.
                w_sec = 1'b1;
            end else if (r_syn1 <= PAR_W'(CODE_W - 1)) begin
                w_sec = 1'b1;
                for (int i = 0; i < CODE_W - 1; i++)
                    if (r_syn1 == PAR_W'(i + 1)) w_fix[i] = ~r_cw1[i];
            end else begin
                // Syndrome points beyond the codeword, so this must be a multi-bit error.
                w_ded = 1'b1;
            end
        end else if (r_syn1 != '0) begin
            w_ded = 1'b1;
        end
    end

    for (genvar k = 0; k < DATA_W; k++) begin : g_ext
        assign w_data[k] = w_fix[f_dpos(k) - 1];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_v1   <= 1'b0;
            r_cw1  <= '0;
            r_syn1 <= '0;
            r_pa1  <= 1'b0;
        end else if (w_rdy) begin
            r_v1 <= vld_i;
            if (vld_i) begin
                r_cw1  <= dat_i[CODE_W-2:0];
                r_syn1 <= w_syn;
                r_pa1  <= w_pa;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_v2  <= 1'b0;
            r_dat <= '0;
            r_sec <= 1'b0;
            r_ded <= 1'b0;
        end else if (w_go1) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_dat <= w_data;
                r_sec <= w_sec;
                r_ded <= w_ded;
            end
        end
    end

    // Counters advance only on delivered words. A clear takes priority over a same-cycle increment.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sec_cnt <= '0;
            r_ded_cnt <= '0;
        end else if (cnt_clr_i) begin
            r_sec_cnt <= '0;
            r_ded_cnt <= '0;
        end else if (w_xfer) begin
            if (r_sec && !(&r_sec_cnt)) r_sec_cnt <= r_sec_cnt + 1'b1;
            if (r_ded && !(&r_ded_cnt)) r_ded_cnt <= r_ded_cnt + 1'b1;
        end
    end

    assign rdy_o     = w_rdy;
    assign vld_o     = r_v2;
    assign dat_o     = r_dat;
    assign err_sec_o = r_sec;
    assign err_ded_o = r_ded;
    assign sec_cnt_o = r_sec_cnt;
    assign ded_cnt_o = r_ded_cnt;

endmodule

// File: tb/tb_secded_decoder.sv
// Scoreboard bench for secded_decoder (DATA_W=16, CODE_W=22), plus a CNT_W=2
// instance for counter saturation and the clear-versus-increment priority.
module tb_secded_decoder;

    logic        clk;
    logic        rst_n;
    logic [21:0] dat_i;
    logic        vld_i;
    logic        rdy_o;
    logic [15:0] dat_o;
    logic        err_sec_o, err_ded_o, vld_o;
    logic        rdy_i;
    logic        cnt_clr_i;
    logic [15:0] sec_cnt_o, ded_cnt_o;

    logic [21:0] s_dat;
    logic        s_vld, s_rdy_o, s_rdy_i, s_clr;
    logic [15:0] s_dat_o;
    logic        s_sec, s_ded, s_vo;
    logic [1:0]  s_sec_cnt, s_ded_cnt;

    typedef struct {
        logic [15:0] d;
        logic        sec;
        logic        ded;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   rdy_mode = 0;   // 0: always ready, 1: random, 2: stalled

    secded_decoder #(.DATA_W(16), .CNT_W(16)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .dat_i(dat_i), .vld_i(vld_i), .rdy_o(rdy_o),
        .dat_o(dat_o), .err_sec_o(err_sec_o), .err_ded_o(err_ded_o), .vld_o(vld_o),
        .rdy_i(rdy_i), .cnt_clr_i(cnt_clr_i), .sec_cnt_o(sec_cnt_o), .ded_cnt_o(ded_cnt_o)
    );

    secded_decoder #(.DATA_W(16), .CNT_W(2)) u_sat (
        .clk_i(clk), .rst_ni(rst_n), .dat_i(s_dat), .vld_i(s_vld), .rdy_o(s_rdy_o),
        .dat_o(s_dat_o), .err_sec_o(s_sec), .err_ded_o(s_ded), .vld_o(s_vo),
        .rdy_i(s_rdy_i), .cnt_clr_i(s_clr), .sec_cnt_o(s_sec_cnt), .ded_cnt_o(s_ded_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference encoder for the stream phase.
    function automatic logic [21:0] enc(input logic [15:0] d);
        logic [21:0] c;
        logic        p;
        int          k;
        c = '0;
        k = 0;
        for (int pos = 1; pos <= 21; pos++)
            if ((pos & (pos - 1)) != 0) begin
                c[pos-1] = d[k];
                k++;
            end
        for (int b = 0; b < 5; b++) begin
            p = 1'b0;
            for (int pos = 1; pos <= 21; pos++)
                if (((pos >> b) & 1) == 1) p = p ^ c[pos-1];
            c[(1 << b) - 1] = p;
        end
        c[21] = ^c[20:0];
        return c;
    endfunction

    // Consumer-ready driver
    initial begin
        rdy_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0)      rdy_i = 1'b1;
            else if (rdy_mode == 1) rdy_i = 1'($urandom_range(0, 1));
            else                    rdy_i = 1'b0;
        end
    end

    // Monitor: pops on each output transfer and checks that the output holds under stall.
    initial begin
        exp_t        e;
        logic        hold;
        logic [15:0] h_dat;
        logic        h_sec, h_ded;
        hold = 1'b0;
        h_dat = '0;
        h_sec = 1'b0;
        h_ded = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold = 1'b0;
            end else begin
                if (hold)
                    chk("hold_stable", {13'd0, vld_o, err_sec_o, err_ded_o, dat_o},
                        {13'd0, 1'b1, h_sec, h_ded, h_dat});
                if (vld_o && rdy_i) begin
                    if (q.size() == 0) begin
                        chk("unexpected_word", 32'(dat_o), 32'hFFFF_FFFF);
                    end else begin
                        e = q.pop_front();
                        chk("dat_o", 32'(dat_o), 32'(e.d));
                        chk("flags", {30'd0, err_sec_o, err_ded_o}, {30'd0, e.sec, e.ded});
                    end
                end
                hold  = vld_o && !rdy_i;
                h_dat = dat_o;
                h_sec = err_sec_o;
                h_ded = err_ded_o;
            end
        end
    end

    // Entered and left at posedge+#1.
    task automatic send(input logic [21:0] cw, input logic [15:0] d, input logic sec, input logic ded);
        int n;
        exp_t e;
        n = 0;
        vld_i = 1'b1;
        dat_i = cw;
        forever begin
            @(negedge clk);
            if (rdy_o) begin
                e.d = d;
                e.sec = sec;
                e.ded = ded;
                q.push_back(e);
                break;
            end
            n++;
            if (n > 200) begin
                chk("send_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        vld_i = 1'b0;
        dat_i = 22'($urandom);   // must be ignored while vld_i=0
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        chk("drain_empty", 32'(q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input string nm, input int sec, input int ded);
        chk({nm, "_sec_cnt"}, 32'(sec_cnt_o), 32'(sec));
        chk({nm, "_ded_cnt"}, 32'(ded_cnt_o), 32'(ded));
    endtask

    task automatic sat_send(input int n);
        s_vld = 1'b1;
        s_dat = 22'h200003;
        repeat (n) @(posedge clk);
        #1;
        s_vld = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        vld_i = 1'b0;
        dat_i = '0;
        cnt_clr_i = 1'b0;
        s_dat = '0;
        s_vld = 1'b0;
        s_rdy_i = 1'b1;
        s_clr = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_vld_o", 32'(vld_o), 32'd0);
        chk("rst_dat_o", 32'(dat_o), 32'd0);
        chk("rst_flags", {30'd0, err_sec_o, err_ded_o}, 32'd0);
        chk("rst_rdy_o", 32'(rdy_o), 32'd1);
        chk_cnt("rst", 0, 0);
        rst_n = 1'b1;

        // Clean zero word, with a latency check
        send(22'h000000, 16'h0000, 1'b0, 1'b0);
        chk("lat_vld_early", 32'(vld_o), 32'd0);
        @(posedge clk);
        #1;
        chk("lat_vld_2cyc", 32'(vld_o), 32'd1);
        drain();
        chk_cnt("zero", 0, 0);

        send(22'h200007, 16'h0001, 1'b0, 1'b0);
        drain();
        chk_cnt("clean1", 0, 0);

        send(22'h200003, 16'h0001, 1'b1, 1'b0);
        drain();
        chk_cnt("sec_bit2", 1, 0);

        send(22'h000007, 16'h0001, 1'b1, 1'b0);
        drain();
        chk_cnt("sec_ovp", 2, 0);

        send(22'h200004, 16'h0001, 1'b0, 1'b1);
        drain();
        chk_cnt("ded", 2, 1);

        // Clean stream with random gaps, random ready and a 5-cycle stall.
        rdy_mode = 1;
        fork
            begin
                for (int i = 0; i < 256; i++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    send(enc(16'(i)), 16'(i), 1'b0, 1'b0);
                end
            end
            begin
                repeat (40) @(posedge clk);
                rdy_mode = 2;
                repeat (5) @(posedge clk);
                rdy_mode = 1;
            end
        join
        rdy_mode = 0;
        drain();
        chk_cnt("stream", 2, 1);

        // Assert reset while stalled with both stages full.
        rdy_mode = 2;
        @(posedge clk);
        #1;
        send(22'h200003, 16'h0001, 1'b1, 1'b0);
        send(22'h200004, 16'h0001, 1'b0, 1'b1);
        chk("stall_vld_o", 32'(vld_o), 32'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_vld_o", 32'(vld_o), 32'd0);
        chk("midrst_dat_o", 32'(dat_o), 32'd0);
        chk("midrst_flags", {30'd0, err_sec_o, err_ded_o}, 32'd0);
        chk("midrst_rdy_o", 32'(rdy_o), 32'd1);
        chk_cnt("midrst", 0, 0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        rdy_mode = 0;
        @(posedge clk);
        #1;
        send(enc(16'hA5C3), 16'hA5C3, 1'b0, 1'b0);
        drain();

        // Saturation on the CNT_W=2 instance
        sat_send(2);
        chk("sat_cnt2", 32'(s_sec_cnt), 32'd2);
        sat_send(3);
        chk("sat_cnt_stick", 32'(s_sec_cnt), 32'd3);
        chk("sat_ded_cnt", 32'(s_ded_cnt), 32'd0);

        // Clear coincides with a SEC output transfer.
        s_vld = 1'b1;
        s_dat = 22'h200003;
        @(posedge clk);
        #1;
        s_vld = 1'b0;
        @(posedge clk);
        #1;
        chk("clr_vo", {30'd0, s_vo, s_sec}, 32'd3);
        s_clr = 1'b1;
        @(posedge clk);
        #1;
        s_clr = 1'b0;
        chk("clr_wins", 32'(s_sec_cnt), 32'd0);
        sat_send(1);
        chk("after_clr", 32'(s_sec_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/secded_decoder.md
Name: secded_decoder

Overview:
- Parametrised next-generation Hamming decoder: SECDED (single-error-correct, double-error-detect) using an extra overall-parity bit.
- Data width is generic, the datapath is a two-stage elastic valid/ready pipeline, and each output word carries error flags.
- Saturating error counters are provided for channel monitoring.
- Sits at the receive end of the channel, after the matching SECDED coder and before the data consumer.

Parameters:
- DATA_W, 16, data bits per word (4..57).
- PAR_W, derived, smallest p with 2^p >= DATA_W+p+1 (5 for 16); localparam, not overridable.
- CODE_W, derived, DATA_W+PAR_W+1 (22 for 16); localparam.
- CNT_W, 16, width of each error counter.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- dat_i  in  CODE_W  received codeword.
- vld_i  in  1  dat_i valid.
- rdy_o  out  1  decoder can accept dat_i this cycle.
- dat_o  out  DATA_W  corrected data.
- err_sec_o  out  1  word had a single error, now corrected; qualified by vld_o.
- err_ded_o  out  1  word had an uncorrectable error; qualified by vld_o.
- vld_o  out  1  dat_o/flags valid.
- rdy_i  in  1  consumer ready.
- cnt_clr_i  in  1  synchronous clear of both counters.
- sec_cnt_o  out  CNT_W  count of delivered SEC words, saturating.
- ded_cnt_o  out  CNT_W  count of delivered DED words, saturating.

Behaviour:
- Codeword layout:
  - Index i in [0, CODE_W-2] is Hamming position i+1.
  - Parity bits sit at power-of-two positions; data bits fill the remaining positions in ascending order, LSB first.
  - Index CODE_W-1 is the overall parity bit, even over the whole word.
- Stage 1 registers the word plus:
  - s = XOR of the positions of all set bits in [CODE_W-2:0];
  - pa = XOR of all CODE_W bits.
- Stage 2 classifies:
  - pa=0, s=0: clean, no flags.
  - pa=1, s=0: overall parity bit in error; data untouched; err_sec=1.
  - pa=1, 1<=s<=CODE_W-1: flip bit at position s, extract data; err_sec=1.
  - pa=1, s>CODE_W-1: err_ded=1, data extracted uncorrected.
  - pa=0, s!=0: err_ded=1, data extracted uncorrected.
  - err_sec and err_ded are never both 1.
- Handshake, elastic pipeline:
  - Stage-1 advance go1 = ~v2 | rdy_i.
  - rdy_o = ~v1 | go1 (combinational from rdy_i permitted).
  - vld_o = v2.
  - A transfer occurs on vld & rdy high at the same edge.
  - vld_o, dat_o and the flags stay stable while vld_o=1 and rdy_i=0.
  - dat_i is ignored when vld_i=0.
- Latency: 2 cycles from input transfer to vld_o when unstalled; sustained throughput 1 word/cycle with rdy_i=1.
- Counters:
  - On each output transfer, sec_cnt_o increments if err_sec_o=1 and ded_cnt_o increments if err_ded_o=1.
  - Both saturate at 2^CNT_W-1 with no wrap.
  - cnt_clr_i wins over a same-cycle increment; the counters read 0 next cycle.
- Reset (rst_ni=0, asynchronous, any time including mid-stall):
  - Outputs: vld_o=0, dat_o=0, err_sec_o=0, err_ded_o=0, sec_cnt_o=0, ded_cnt_o=0.
  - rdy_o=1, since both stages are empty.
  - In-flight words are discarded.
  - Release is synchronous to clk_i; the first transfer is possible on the first edge after deassertion.

Test Plan (DATA_W=16, CODE_W=22):
- Reset, then dat_i=0x000000 with vld_i=1 -> 2 cycles later vld_o=1, dat_o=0x0000, no flags; counters stay 0.
- dat_i=0x200007 (clean encoding of 0x0001) -> dat_o=0x0001, no flags.
- dat_i=0x200003 (bit 2 flipped) -> dat_o=0x0001, err_sec_o=1, sec_cnt_o=1.
- dat_i=0x000007 (overall parity bit flipped) -> dat_o=0x0001, err_sec_o=1.
- dat_i=0x200004 (bits 0 and 1 flipped) -> err_ded_o=1, dat_o=0x0001 (raw), ded_cnt_o=1.
- Back-pressure and reset:
  - Stream 0x0000..0x00FF clean with random vld_i/rdy_i; rdy_i=0 for 5 cycles -> no word lost or duplicated, outputs held stable, order preserved.
  - Assert rst_ni mid-stall -> vld_o=0 immediately.
- Counter saturation: CNT_W=2, 5 SEC words -> sec_cnt_o sticks at 3; cnt_clr_i pulsed together with a SEC transfer -> sec_cnt_o=0.
